// File: rtl/mux_uart_pkg.sv
// Shared definitions for the mux_uart serial console port:
// register offsets, status bit positions and the common FSM state type.
package mux_uart_pkg;

   localparam logic [15:0] STATUS_OFS = 16'd0;
   localparam logic [15:0] DATA_OFS   = 16'd1;

   localparam int RX_READY_BIT = 0;
   localparam int TX_EMPTY_BIT = 1;
   localparam int OVERRUN_BIT  = 2;
   localparam int FRAMING_BIT  = 3;
   localparam int LOOPBACK_BIT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/mux_uart_rx.sv
// 8N1 receiver for mux_uart: 2-flop input synchronizer, start-bit
// validation at mid-bit, LSB-first data sampling and stop-bit check.
// Emits the received byte with a one-cycle delivery strobe; the framing
// flag is valid alongside the strobe.
module mux_uart_rx
   import mux_uart_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] rx_byte,
   output logic       rx_strobe,
   output logic       rx_frame_err
);

   localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        prev_q, prev_d;
   uart_state_e state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        strobe_q, strobe_d;
   logic        ferr_q, ferr_d;
   logic        fall;

   assign fall = prev_q & ~sync2_q;

   // Receive FSM next state, synchronizer chain and sampling datapath
   always_comb begin
      sync1_d  = rx_in;
      sync2_d  = sync1_q;
      prev_d   = sync2_q;
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      strobe_d = 1'b0;
      ferr_d   = ferr_q;
      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = START;
               baud_d  = 16'd0;
            end
         end
         START: begin
            if (baud_q == HALF_LAST) begin
               baud_d  = 16'd0;
               bit_d   = 3'd0;
               // A line that is high again at mid-start was a glitch.
               state_d = sync2_q ? IDLE : DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = 16'd0;
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d   = 16'd0;
               strobe_d = 1'b1;
               ferr_d   = ~sync2_q;
               state_d  = IDLE;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Receiver state registers; reset discards any partial frame
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         prev_q   <= 1'b1;
         state_q  <= IDLE;
         baud_q   <= 16'd0;
         bit_q    <= 3'd0;
         shift_q  <= 8'd0;
         strobe_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         strobe_q <= strobe_d;
         ferr_q   <= ferr_d;
      end
   end

   assign rx_byte      = shift_q;
   assign rx_strobe    = strobe_q;
   assign rx_frame_err = ferr_q;

endmodule

// File: rtl/mux_uart.sv
// Memory-mapped 8N1 serial console on the CPU6 bus. Status at BASE_ADDR,
// data at BASE_ADDR+1; read data is registered one cycle after the address,
// like Memory. Holds the transmitter, register file and bus decode.
// Optional build macro MUX_UART_LOOPBACK_EN adds status bit4 (loopback).
module mux_uart
   import mux_uart_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'hF200,
   parameter int          CLK_DIV   = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic        write_en,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        sel_out,
   input  logic        rxd,
   output logic        txd
);

   localparam logic [15:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;
   localparam logic [15:0] DATA_ADDR   = BASE_ADDR + DATA_OFS;
   localparam logic [15:0] BAUD_LAST   = 16'(CLK_DIV - 1);

   logic        hit_status, hit_data, rd_sel, rd_data, wr_status, wr_data, consume;
   logic [7:0]  status;
   logic        rx_line;
   logic [7:0]  rx_byte;
   logic        rx_strobe, rx_frame_err;

   logic [7:0]  data_out_q, data_out_d;
   logic        sel_q, sel_d;
   logic        rd_prev_q, rd_prev_d;
   logic        rx_ready_q, rx_ready_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        ovr_q, ovr_d;
   logic        fe_q, fe_d;

   logic [7:0]  hold_q, hold_d;
   logic        tx_empty_q, tx_empty_d;
   uart_state_e tx_state_q, tx_state_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [15:0] tx_baud_q, tx_baud_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic        txd_q, txd_d;

   assign hit_status = (address == STATUS_ADDR);
   assign hit_data   = (address == DATA_ADDR);
   assign rd_sel     = (hit_status | hit_data) & ~write_en;
   assign rd_data    = hit_data & ~write_en;
   assign wr_status  = hit_status & write_en;
   assign wr_data    = hit_data & write_en;
   // Only the first cycle of a held data read consumes the byte.
   assign consume    = rd_data & ~rd_prev_q;

`ifdef MUX_UART_LOOPBACK_EN
   logic loop_q, loop_d;

   // Loopback bit register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) loop_q <= 1'b0;
      else        loop_q <= loop_d;
   end

   // Loopback bit is written by any status write
   always_comb begin
      loop_d = loop_q;
      if (wr_status) loop_d = data_in[LOOPBACK_BIT];
   end

   assign rx_line = loop_q ? txd_q : rxd;
   assign txd     = loop_q ? 1'b1 : txd_q;
`else
   assign rx_line = rxd;
   assign txd     = txd_q;
`endif

   // Assemble the status byte from the live flags
   always_comb begin
      status               = 8'h00;
      status[RX_READY_BIT] = rx_ready_q;
      status[TX_EMPTY_BIT] = tx_empty_q;
      status[OVERRUN_BIT]  = ovr_q;
      status[FRAMING_BIT]  = fe_q;
`ifdef MUX_UART_LOOPBACK_EN
      status[LOOPBACK_BIT] = loop_q;
`endif
   end

   mux_uart_rx #(
      .CLK_DIV(CLK_DIV)
   ) u_rx (
      .clock       (clock),
      .reset       (reset),
      .rx_in       (rx_line),
      .rx_byte     (rx_byte),
      .rx_strobe   (rx_strobe),
      .rx_frame_err(rx_frame_err)
   );

   // Bus read mux and receive-side flags; error sets beat a status-write clear
   always_comb begin
      sel_d      = rd_sel;
      rd_prev_d  = rd_data;
      data_out_d = rd_sel ? (hit_data ? rx_data_q : status) : 8'h00;
      rx_ready_d = rx_ready_q;
      rx_data_d  = rx_data_q;
      ovr_d      = ovr_q;
      fe_d       = fe_q;
      if (wr_status) begin
         ovr_d = 1'b0;
         fe_d  = 1'b0;
      end
      if (rx_strobe) begin
         if (rx_frame_err) fe_d = 1'b1;
         if (!rx_ready_q || consume) begin
            rx_data_d  = rx_byte;
            rx_ready_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (consume) begin
         rx_ready_d = 1'b0;
      end
   end

   // Bus and receive-flag registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_out_q <= 8'h00;
         sel_q      <= 1'b0;
         rd_prev_q  <= 1'b0;
         rx_ready_q <= 1'b0;
         rx_data_q  <= 8'h00;
         ovr_q      <= 1'b0;
         fe_q       <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         sel_q      <= sel_d;
         rd_prev_q  <= rd_prev_d;
         rx_ready_q <= rx_ready_d;
         rx_data_q  <= rx_data_d;
         ovr_q      <= ovr_d;
         fe_q       <= fe_d;
      end
   end

   // Holding register load and transmit FSM next state
   always_comb begin
      hold_d     = hold_q;
      tx_empty_d = tx_empty_q;
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      txd_d      = txd_q;
      // A write to a full holding register is dropped.
      if (wr_data && tx_empty_q) begin
         hold_d     = data_in;
         tx_empty_d = 1'b0;
      end
      case (tx_state_q)
         IDLE: begin
            if (!tx_empty_q) begin
               tx_state_d = START;
               tx_shift_d = hold_q;
               tx_empty_d = 1'b1;
               tx_baud_d  = 16'd0;
               txd_d      = 1'b0;
            end
         end
         START: begin
            if (tx_baud_q == BAUD_LAST) begin
               tx_state_d = DATA;
               tx_baud_d  = 16'd0;
               tx_bit_d   = 3'd0;
               txd_d      = tx_shift_q[0];
            end else begin
               tx_baud_d = tx_baud_q + 16'd1;
            end
         end
         DATA: begin
            if (tx_baud_q == BAUD_LAST) begin
               tx_baud_d  = 16'd0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = STOP;
                  txd_d      = 1'b1;
               end else begin
                  txd_d = tx_shift_q[1];
               end
            end else begin
               tx_baud_d = tx_baud_q + 16'd1;
            end
         end
         STOP: begin
            if (tx_baud_q == BAUD_LAST) begin
               tx_baud_d = 16'd0;
               // A queued byte starts immediately: no idle gap between frames.
               if (!tx_empty_q) begin
                  tx_state_d = START;
                  tx_shift_d = hold_q;
                  tx_empty_d = 1'b1;
                  txd_d      = 1'b0;
               end else begin
                  tx_state_d = IDLE;
               end
            end else begin
               tx_baud_d = tx_baud_q + 16'd1;
            end
         end
         default: tx_state_d = IDLE;
      endcase
   end

   // Transmit state registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_q     <= 8'h00;
         tx_empty_q <= 1'b1;
         tx_state_q <= IDLE;
         tx_shift_q <= 8'h00;
         tx_baud_q  <= 16'd0;
         tx_bit_q   <= 3'd0;
         txd_q      <= 1'b1;
      end else begin
         hold_q     <= hold_d;
         tx_empty_q <= tx_empty_d;
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         txd_q      <= txd_d;
      end
   end

   assign data_out = data_out_q;
   assign sel_out  = sel_q;

endmodule

// File: tb/tb_mux_uart.sv
// Directed bench for mux_uart at CLK_DIV=16: register reads, transmit
// framing, back-to-back transmit, receive, overrun, framing error, glitch
// rejection, reset mid-frame and (when built with it) loopback.
module tb_mux_uart;

   localparam int CLKD = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] address;
   logic        write_en;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        sel_out;
   logic        rxd;
   logic        txd;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic txd_log [0:16383];

   mux_uart #(
      .BASE_ADDR(16'hF200),
      .CLK_DIV  (CLKD)
   ) dut (
      .clock   (clk),
      .reset   (reset),
      .address (address),
      .write_en(write_en),
      .data_in (data_in),
      .data_out(data_out),
      .sel_out (sel_out),
      .rxd     (rxd),
      .txd     (txd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) if (cyc < 16384) txd_log[cyc] = txd;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (time %0t, required finish earlier)", $time);
      $fatal(1);
   end

   // One-cycle bus read, called at posedge+1; returns registered result.
   task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic s);
      address  = a;
      write_en = 1'b0;
      @(posedge clk); #1;
      d = data_out;
      s = sel_out;
      address = 16'h0000;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      address  = a;
      write_en = 1'b1;
      data_in  = d;
      @(posedge clk); #1;
      write_en = 1'b0;
      address  = 16'h0000;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stopb);
      rxd = 1'b0;
      idle(CLKD);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         idle(CLKD);
      end
      rxd = stopb;
      idle(CLKD);
      rxd = 1'b1;
   endtask

   // Expected txd k cycles into a frame (k=1 is the first start-bit cycle).
   function automatic logic exp_tx(input logic [7:0] b, input int k);
      int idx;
      idx = (k - 1) / CLKD;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      return 1'b1;
   endfunction

   task automatic test_reset();
      logic [7:0] d;
      logic s;
      reset = 1'b0; address = 16'hF200; write_en = 1'b0; data_in = 8'h00; rxd = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (txd !== 1'b1 || data_out !== 8'h00 || sel_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: txd=%b data_out=%h sel=%b, required 1/00/0", txd, data_out, sel_out);
      end
      reset = 1'b1;
      address = 16'h0000;
      idle(1);
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h02 || s !== 1'b1) begin
         errors++;
         $display("FAIL reset_status: got %h sel %b, required 02 sel 1", d, s);
      end
      bus_read(16'h1000, d, s);
      checks++;
      if (d !== 8'h00 || s !== 1'b0) begin
         errors++;
         $display("FAIL other_addr: got %h sel %b, required 00 sel 0", d, s);
      end
      bus_write(16'hF200, 8'h00);
      checks++;
      if (sel_out !== 1'b0) begin
         errors++;
         $display("FAIL write_no_sel: sel %b, required 0", sel_out);
      end
   endtask

   task automatic test_tx_single();
      logic [7:0] d;
      logic s;
      int w, bad, first;
      bus_write(16'hF201, 8'h55);
      w = cyc;
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL tx_status_full: got %h, required 00", d);
      end
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h02) begin
         errors++;
         $display("FAIL tx_status_empty_again: got %h, required 02", d);
      end
      idle(180);
      bad = 0; first = -1;
      for (int k = 1; k <= 175; k++) begin
         if (txd_log[w+k] !== exp_tx(8'h55, k)) begin
            bad++;
            if (first < 0) first = k;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL tx_frame_55: %0d wrong cycles (first at %0d), required 0", bad, first);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      logic s;
      logic e;
      int w, bad, first;
      bus_write(16'hF201, 8'hA5);
      w = cyc;
      idle(1);
      bus_write(16'hF201, 8'h3C);
      bus_write(16'hF201, 8'h77);
      idle(370);
      bad = 0; first = -1;
      for (int k = 1; k <= 360; k++) begin
         if (k <= 160)      e = exp_tx(8'hA5, k);
         else if (k <= 320) e = exp_tx(8'h3C, k - 160);
         else               e = 1'b1;
         if (txd_log[w+k] !== e) begin
            bad++;
            if (first < 0) first = k;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL tx_back_to_back: %0d wrong cycles (first at %0d), required 0", bad, first);
      end
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h02) begin
         errors++;
         $display("FAIL b2b_status: got %h, required 02", d);
      end
   endtask

   task automatic test_rx_basic();
      logic [7:0] d;
      logic s;
      send_rx(8'hC3, 1'b1);
      idle(3);
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h03) begin
         errors++;
         $display("FAIL rx_status_ready: got %h, required 03", d);
      end
      address = 16'hF201;
      write_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (data_out !== 8'hC3 || sel_out !== 1'b1) begin
            errors++;
            $display("FAIL rx_held_read%0d: got %h sel %b, required C3 sel 1", i, data_out, sel_out);
         end
      end
      address = 16'h0000;
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h02) begin
         errors++;
         $display("FAIL rx_status_consumed: got %h, required 02", d);
      end
   endtask

   task automatic test_rx_overrun();
      logic [7:0] d;
      logic s;
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      idle(3);
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h07) begin
         errors++;
         $display("FAIL ovr_status: got %h, required 07", d);
      end
      bus_read(16'hF201, d, s);
      checks++;
      if (d !== 8'h11) begin
         errors++;
         $display("FAIL ovr_data: got %h, required 11", d);
      end
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h06) begin
         errors++;
         $display("FAIL ovr_after_read: got %h, required 06", d);
      end
      bus_write(16'hF200, 8'h00);
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h02) begin
         errors++;
         $display("FAIL ovr_cleared: got %h, required 02", d);
      end
   endtask

   task automatic test_framing_glitch();
      logic [7:0] d;
      logic s;
      send_rx(8'h5A, 1'b0);
      idle(3);
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h0B) begin
         errors++;
         $display("FAIL fe_status: got %h, required 0B", d);
      end
      bus_read(16'hF201, d, s);
      checks++;
      if (d !== 8'h5A) begin
         errors++;
         $display("FAIL fe_data: got %h, required 5A", d);
      end
      bus_write(16'hF200, 8'h00);
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h02) begin
         errors++;
         $display("FAIL fe_cleared: got %h, required 02", d);
      end
      rxd = 1'b0;
      idle(3);
      rxd = 1'b1;
      idle(200);
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h02) begin
         errors++;
         $display("FAIL glitch_status: got %h, required 02", d);
      end
      send_rx(8'h81, 1'b1);
      idle(3);
      bus_read(16'hF201, d, s);
      checks++;
      if (d !== 8'h81) begin
         errors++;
         $display("FAIL after_glitch_data: got %h, required 81", d);
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      logic s;
      rxd = 1'b0;
      bus_write(16'hF201, 8'h00);
      idle(30);
      checks++;
      if (txd !== 1'b0) begin
         errors++;
         $display("FAIL midframe_txd_low: txd %b, required 0", txd);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (txd !== 1'b1) begin
         errors++;
         $display("FAIL midframe_reset_txd: txd %b, required 1", txd);
      end
      rxd = 1'b1;
      idle(2);
      reset = 1'b1;
      idle(200);
      checks++;
      if (txd !== 1'b1) begin
         errors++;
         $display("FAIL midframe_txd_idle: txd %b, required 1", txd);
      end
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h02) begin
         errors++;
         $display("FAIL midframe_status: got %h, required 02", d);
      end
   endtask

`ifdef MUX_UART_LOOPBACK_EN
   task automatic test_loopback();
      logic [7:0] d;
      logic s;
      int w, bad;
      bus_write(16'hF200, 8'h10);
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h12) begin
         errors++;
         $display("FAIL lb_status: got %h, required 12", d);
      end
      bus_write(16'hF201, 8'h9E);
      w = cyc;
      idle(180);
      bad = 0;
      for (int k = 1; k <= 175; k++) if (txd_log[w+k] !== 1'b1) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL lb_txd_held: %0d low cycles, required 0", bad);
      end
      bus_read(16'hF200, d, s);
      checks++;
      if (d !== 8'h13) begin
         errors++;
         $display("FAIL lb_status_ready: got %h, required 13", d);
      end
      bus_read(16'hF201, d, s);
      checks++;
      if (d !== 8'h9E) begin
         errors++;
         $display("FAIL lb_data: got %h, required 9E", d);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_tx_single();
      test_back_to_back();
      test_rx_basic();
      test_rx_overrun();
      test_framing_glitch();
      test_reset_midframe();
`ifdef MUX_UART_LOOPBACK_EN
      test_loopback();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
